// File: rtl/collision_scheduler_if.sv
// collision_scheduler_if: frame request, blue position, tile table port and contact result bundle
//   frame_start  scan request pulse          x_blue/y_blue  blue block top-left
//   tile_addr    table read address          tile_x/tile_y/tile_valid  entry read back one cycle later
//   busy/done    scan status / end pulse     contact        {left,right,up,down}
interface collision_scheduler_if #(
    parameter int ADDR_W = 3
);
    logic              frame_start;
    logic [9:0]        x_blue;
    logic [8:0]        y_blue;
    logic [ADDR_W-1:0] tile_addr;
    logic [9:0]        tile_x;
    logic [8:0]        tile_y;
    logic              tile_valid;
    logic              busy;
    logic              done;
    logic [3:0]        contact;
    modport master (
        output frame_start, x_blue, y_blue, tile_x, tile_y, tile_valid,
        input  tile_addr, busy, done, contact
    );
    modport slave (
        input  frame_start, x_blue, y_blue, tile_x, tile_y, tile_valid,
        output tile_addr, busy, done, contact
    );
endinterface

// File: rtl/collision_scheduler.sv
// collision_scheduler: per-frame pipelined scan of the tile table, ORing side contacts of the blue block
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of collision_scheduler_if (frame_start, blue position, tile port, busy/done/contact)
module collision_scheduler #(
    parameter int N_TILES = 8,
    parameter int ADDR_W  = 3,
    parameter int BW      = 23,
    parameter int BH      = 45,
    parameter int TW      = 25,
    parameter int TH      = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    collision_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TILES - 1);
    localparam logic [10:0] BW11 = 11'(BW);
    localparam logic [10:0] BH11 = 11'(BH);
    localparam logic [10:0] TW11 = 11'(TW);
    localparam logic [10:0] TH11 = 11'(TH);
    state_t            state, next;
    logic [ADDR_W-1:0] addr;
    logic [9:0]        xs;
    logic [8:0]        ys;
    logic [3:0]        acc, contact, hit;
    logic              vld, busy, done;
    logic [10:0]       xb, yb, xg, yg, xr;
    logic              xo, yo, dn, up, rt, lf;
    assign bus.tile_addr = addr;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.contact   = contact;
    assign xb = {1'b0, xs};
    assign yb = {2'b0, ys};
    assign xg = {1'b0, bus.tile_x};
    assign yg = {2'b0, bus.tile_y};
    assign xr = xb + BW11;
    assign xo = (xr > xg + 11'd2) && (xr < xg + TW11 + 11'd1);
    assign yo = (yb + 11'd2 < yg + TH11) && (yb + BH11 > yg + 11'd2);
    assign dn = xo && (yb + BH11 == yg);
    assign up = xo && (yb == yg + TH11);
    assign rt = (xr == xg) && yo;
    assign lf = (xb == xg + TW11) && yo;
    // vld marks that the table data on the port belongs to an address issued last cycle
    assign hit = (vld && bus.tile_valid) ? {lf, rt, up, dn} : 4'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.frame_start ? SCAN : IDLE;
            SCAN:    next = (addr == LAST) ? DRAIN : SCAN;
            DRAIN:   next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            xs      <= '0;
            ys      <= '0;
            acc     <= '0;
            contact <= '0;
            vld     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            vld  <= (state == SCAN);
            case (state)
                IDLE: if (bus.frame_start) begin
                    xs   <= bus.x_blue;
                    ys   <= bus.y_blue;
                    acc  <= '0;
                    addr <= '0;
                    busy <= 1'b1;
                end
                SCAN: begin
                    acc <= acc | hit;
                    if (addr != LAST) addr <= addr + ADDR_W'(1);
                end
                DRAIN: begin
                    contact <= acc | hit;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    addr    <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler: directed scans against hand-computed contact vectors and scan timing
module tb_collision_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    logic [9:0] tx_t [8];
    logic [8:0] ty_t [8];
    logic       tv_t [8];
    collision_scheduler_if #(.ADDR_W(3)) bus ();
    collision_scheduler #(
        .N_TILES(8), .ADDR_W(3), .BW(23), .BH(45), .TW(25), .TH(24)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        bus.tile_x     <= tx_t[bus.tile_addr];
        bus.tile_y     <= ty_t[bus.tile_addr];
        bus.tile_valid <= tv_t[bus.tile_addr];
    end
    always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic clr();
        for (int i = 0; i < 8; i++) begin
            tx_t[i] = '0;
            ty_t[i] = '0;
            tv_t[i] = 1'b0;
        end
    endtask
    task automatic put(input int i, input int x, input int y, input logic v);
        tx_t[i] = 10'(x);
        ty_t[i] = 9'(y);
        tv_t[i] = v;
    endtask
    // act: 0 plain, 1 move x_blue after two edges, 2 extra frame_start mid-scan
    task automatic scan(input string tag, input int act, input logic [3:0] exp_c, input logic [3:0] hold_c);
        int n, bc, d0;
        d0 = done_cnt;
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        n = 0;
        bc = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            bc += int'(bus.busy);
            if (n == 3) chk({tag, "_addr3"}, 32'(bus.tile_addr), 3);
            if (n == 8) chk({tag, "_addr7"}, 32'(bus.tile_addr), 7);
            if (n == 4) chk({tag, "_hold"}, 32'(bus.contact), 32'(hold_c));
            if (act == 1 && n == 1) bus.x_blue = 10'd300;
            bus.frame_start = (act == 2 && n == 3);
            @(negedge clk);
            n++;
        end
        bus.frame_start = 1'b0;
        chk({tag, "_edges"}, n, 9);
        chk({tag, "_busycyc"}, bc, 9);
        chk({tag, "_contact"}, 32'(bus.contact), 32'(exp_c));
        @(negedge clk);
        chk({tag, "_donelow"}, 32'(bus.done), 0);
        chk({tag, "_ndone"}, done_cnt - d0, 1);
        chk({tag, "_addr0"}, 32'(bus.tile_addr), 0);
        bus.x_blue = 10'd100;
        repeat (2) @(negedge clk);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
    endtask
    initial begin
        int d0;
        clr();
        bus.frame_start = 1'b0;
        bus.x_blue = 10'd100;
        bus.y_blue = 9'd200;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_contact", 32'(bus.contact), 0);
        chk("rst_addr", 32'(bus.tile_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);
        put(0, 100, 245, 1'b1);
        scan("stand", 0, 4'b0001, 4'b0000);
        clr();
        put(1, 100, 245, 1'b1);
        put(3, 100, 176, 1'b1);
        put(6, 123, 200, 1'b1);
        put(7, 75, 200, 1'b1);
        scan("all", 0, 4'b1111, 4'b0001);
        clr();
        put(2, 121, 245, 1'b1);
        scan("x121", 0, 4'b0000, 4'b1111);
        clr();
        put(7, 98, 245, 1'b1);
        scan("x98", 0, 4'b0001, 4'b0000);
        clr();
        put(0, 100, 246, 1'b1);
        scan("y246", 0, 4'b0000, 4'b0001);
        clr();
        put(0, 100, 245, 1'b0);
        scan("inval", 0, 4'b0000, 4'b0000);
        clr();
        put(0, 100, 245, 1'b1);
        scan("snap", 1, 4'b0001, 4'b0000);
        scan("extra", 2, 4'b0001, 4'b0001);
        clr();
        scan("hold", 0, 4'b0000, 4'b0001);
        put(0, 100, 245, 1'b1);
        scan("pre_rst", 0, 4'b0001, 4'b0000);
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_contact", 32'(bus.contact), 0);
        chk("mrst_addr", 32'(bus.tile_addr), 0);
        d0 = done_cnt;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mrst_nodone", done_cnt - d0, 0);
        chk("mrst_idle", 32'(bus.busy), 0);
        scan("post_rst", 0, 4'b0001, 4'b0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
